// File: rtl/fp_pkg.sv
// fp_pkg: op encodings and default field layout shared by the
// fp add/sub pipeline and its users.
package fp_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int FP_E_W = 8;
    localparam int FP_M_W = 23;

    typedef struct packed {
        logic              sign;
        logic [FP_E_W-1:0] exp;
        logic [FP_M_W-1:0] mant;
    } fp_t;

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if: operand-in / result-out valid-ready bundle.
// master drives operands and consumes results; slave is the pipeline.
interface fp_addsub_pipe_if #(
    parameter int E_W = 8,
    parameter int M_W = 23
);
    localparam int W = 1 + E_W + M_W;

    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] p;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, p, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, p, ovf, zero
    );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter; an all-zero input
// returns WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt
);
    always_comb begin
        o_cnt = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_cnt = CNT_W'(WIDTH - 1 - i);
        end
    end
endmodule

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage float add/sub (align, add, normalise) with a
// global stall. FP_ADDSUB_ROUND_EN selects round-nearest-even, else truncate.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int E_W = 8,
    parameter int M_W = 23
) (
    input logic             clk,
    input logic             rst,
    fp_addsub_pipe_if.slave bus
);
    localparam int W   = 1 + E_W + M_W;
    localparam int XW  = M_W + 4;
    localparam int ENW = E_W + 2;
    localparam int LZW = $clog2(XW + 1);
    localparam logic signed [ENW-1:0] EXP_ONE = ENW'(1);
    localparam logic signed [ENW-1:0] EXP_MAX = ENW'((1 << E_W) - 1);

    logic w_adv;
    logic r_out_valid;
    logic [W-1:0] r_p;
    logic r_ovf;
    logic r_zero;

    assign w_adv         = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.p         = r_p;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

    logic [E_W-1:0] w_ea, w_eb, w_big_e, w_sml_e, w_diff;
    logic [M_W:0]   w_ma, w_mb, w_big_m, w_sml_m;
    logic           w_sa, w_sb, w_a_big, w_stk;
    logic [XW-1:0]  w_ext, w_shr, w_mask, w_aln;

    always_comb begin
        w_ea    = bus.a[W-2:M_W];
        w_eb    = bus.b[W-2:M_W];
        w_ma    = (w_ea == '0) ? '0 : {1'b1, bus.a[M_W-1:0]};
        w_mb    = (w_eb == '0) ? '0 : {1'b1, bus.b[M_W-1:0]};
        w_sa    = bus.a[W-1];
        w_sb    = bus.b[W-1] ^ (bus.op == OP_SUB);
        w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};
        w_big_e = w_a_big ? w_ea : w_eb;
        w_sml_e = w_a_big ? w_eb : w_ea;
        w_big_m = w_a_big ? w_ma : w_mb;
        w_sml_m = w_a_big ? w_mb : w_ma;
        w_diff  = w_big_e - w_sml_e;
        // Bits shifted out collapse into the sticky LSB.
        w_ext   = {w_sml_m, 3'b000};
        w_shr   = w_ext >> w_diff;
        w_mask  = ~({XW{1'b1}} << w_diff);
        w_stk   = |(w_ext & w_mask);
        w_aln   = {w_shr[XW-1:1], w_shr[0] | w_stk};
    end

    logic           r1_valid, r1_sign, r1_sub;
    logic [E_W-1:0] r1_exp;
    logic [XW-1:0]  r1_mb, r1_ms;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_sub   <= 1'b0;
            r1_exp   <= '0;
            r1_mb    <= '0;
            r1_ms    <= '0;
        end else if (w_adv) begin
            r1_valid <= bus.in_valid;
            r1_sign  <= w_a_big ? w_sa : w_sb;
            r1_sub   <= w_sa ^ w_sb;
            r1_exp   <= w_big_e;
            r1_mb    <= {w_big_m, 3'b000};
            r1_ms    <= w_aln;
        end
    end

    logic [XW:0] w_sum;
    assign w_sum = r1_sub ? ({1'b0, r1_mb} - {1'b0, r1_ms})
                          : ({1'b0, r1_mb} + {1'b0, r1_ms});

    logic           r2_valid, r2_sign;
    logic [E_W-1:0] r2_exp;
    logic [XW:0]    r2_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_exp   <= '0;
            r2_sum   <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_exp   <= r1_exp;
            r2_sum   <= w_sum;
        end
    end

    logic [LZW-1:0] w_lz;

    fp_lzc #(
        .WIDTH (XW),
        .CNT_W (LZW)
    ) u_lzc (
        .i_data (r2_sum[XW-1:0]),
        .o_cnt  (w_lz)
    );

    logic                  w_carry, w_up, w_zr, w_ovf;
    logic [XW-1:0]         w_norm;
    logic [M_W+1:0]        w_rnd;
    logic signed [ENW-1:0] w_exp_n, w_exp_r;
    logic [W-1:0]          w_p;

    assign w_carry = r2_sum[XW];
    assign w_norm  = w_carry ? {r2_sum[XW:2], |r2_sum[1:0]}
                             : (r2_sum[XW-1:0] << w_lz);
    assign w_exp_n = w_carry ? (ENW'(r2_exp) + EXP_ONE)
                             : (ENW'(r2_exp) - ENW'(w_lz));

`ifdef FP_ADDSUB_ROUND_EN
    assign w_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
`else
    logic w_unused_grs;
    assign w_up         = 1'b0;
    assign w_unused_grs = ^w_norm[2:0];
`endif

    // A rounding carry leaves the fraction all-zero and bumps the exponent.
    assign w_rnd   = {1'b0, w_norm[XW-1:3]} + (M_W+2)'(w_up);
    assign w_exp_r = w_rnd[M_W+1] ? (w_exp_n + EXP_ONE) : w_exp_n;
    assign w_zr    = (r2_sum == '0) || (w_exp_n < EXP_ONE);

    always_comb begin
        w_p   = {r2_sign, w_exp_r[E_W-1:0], w_rnd[M_W-1:0]};
        w_ovf = 1'b0;
        if (w_zr) begin
            w_p = '0;
        end else if (w_exp_r >= EXP_MAX) begin
            w_p   = {r2_sign, {E_W{1'b1}}, {M_W{1'b0}}};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_p         <= w_p;
            r_ovf       <= w_ovf;
            r_zero      <= w_zr;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed and randomized checks of fp_addsub_pipe
// against an exact-integer float reference model.
module tb_fp_addsub_pipe;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fp_addsub_pipe_if #(.E_W(8), .M_W(23)) bus ();

    fp_addsub_pipe #(.E_W(8), .M_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Exact sum of the two values as wide integers, then normalise and
    // truncate or round; returns {ovf, zero, p}.
    function automatic logic [33:0] ref_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic op);
        fp_t fa, fb;
        logic [127:0] x, y, r, m;
        logic sx, sy, s;
        int ea, eb, elo, k, e, sh;
        fa = a;
        fb = b;
        ea = int'(fa.exp);
        eb = int'(fb.exp);
        sx = fa.sign;
        sy = fb.sign ^ (op == OP_SUB);
        x  = (ea == 0) ? 128'd0 : 128'({1'b1, fa.mant});
        y  = (eb == 0) ? 128'd0 : 128'({1'b1, fb.mant});
        if (ea == 0) elo = eb;
        else if (eb == 0) elo = ea;
        else elo = (ea < eb) ? ea : eb;
        if (x != 0) x = x << (ea - elo);
        if (y != 0) y = y << (eb - elo);
        if (sx == sy) begin
            r = x + y; s = sx;
        end else if (x >= y) begin
            r = x - y; s = sx;
        end else begin
            r = y - x; s = sy;
        end
        if (r == 0) return {2'b01, 32'd0};
        k = 127;
        while (r[k] == 1'b0) k--;
        e = elo + k - 23;
        if (e <= 0) return {2'b01, 32'd0};
        if (k > 23) begin
            sh = k - 23;
            m  = r >> sh;
`ifdef FP_ADDSUB_ROUND_EN
            begin
                logic [127:0] rem, half;
                rem  = r - (m << sh);
                half = 128'd1 << (sh - 1);
                if (rem > half || (rem == half && m[0])) m = m + 1;
            end
`endif
        end else begin
            m = r << (23 - k);
        end
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        return {2'b00, s, e[7:0], m[22:0]};
    endfunction

    task automatic gen_op(output logic [31:0] a, output logic [31:0] b,
                          output logic op);
        int ea, eb;
        ea = int'($urandom_range(255, 0));
        if ($urandom_range(9, 0) == 0) ea = 0;
        eb = ea + int'($urandom_range(120, 0)) - 60;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
        a  = {1'($urandom), 8'(ea), 23'($urandom)};
        b  = {1'($urandom), 8'(eb), 23'($urandom)};
        op = 1'($urandom);
        if ($urandom_range(9, 0) == 1) b = a;
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic op, output logic [33:0] res,
                           output int lat);
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.op = op;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {bus.ovf, bus.zero, bus.p};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 1'b0;
        bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.ovf, bus.zero, bus.p} !== 35'd0)
            begin failures++; $display("FAIL reset_state got=%h exp=0",
                {bus.out_valid, bus.ovf, bus.zero, bus.p}); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [33:0] res, expv;
        int lat;
        run_one(32'h3F800000, 32'h3F800000, OP_ADD, res, lat);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL latency got=%0d exp=3", lat); end
        checks++;
        if (res !== {2'b00, 32'h40000000})
            begin failures++; $display("FAIL one_plus_one got=%h exp=%h", res, {2'b00, 32'h40000000}); end
        run_one(32'h3F800000, 32'h3F800000, OP_SUB, res, lat);
        checks++;
        if (res !== {2'b01, 32'h00000000})
            begin failures++; $display("FAIL one_minus_one got=%h exp=%h", res, {2'b01, 32'h0}); end
        run_one(32'h7F7FFFFF, 32'h7F7FFFFF, OP_ADD, res, lat);
        checks++;
        if (res !== {2'b10, 32'h7F800000})
            begin failures++; $display("FAIL overflow got=%h exp=%h", res, {2'b10, 32'h7F800000}); end
`ifdef FP_ADDSUB_ROUND_EN
        expv = {2'b00, 32'h3F800002};
`else
        expv = {2'b00, 32'h3F800001};
`endif
        run_one(32'h3F800001, 32'h33800000, OP_ADD, res, lat);
        checks++;
        if (res !== expv) begin failures++; $display("FAIL round_tie got=%h exp=%h", res, expv); end
        run_one(32'h3F800000, 32'h3FC00000, OP_SUB, res, lat);
        checks++;
        if (res !== {2'b00, 32'hBF000000})
            begin failures++; $display("FAIL neg_result got=%h exp=%h", res, {2'b00, 32'hBF000000}); end
        run_one(32'h00C00000, 32'h00800000, OP_SUB, res, lat);
        checks++;
        if (res !== {2'b01, 32'h00000000})
            begin failures++; $display("FAIL underflow got=%h exp=%h", res, {2'b01, 32'h0}); end
        run_one(32'h00000001, 32'h3F800000, OP_ADD, res, lat);
        checks++;
        if (res !== {2'b00, 32'h3F800000})
            begin failures++; $display("FAIL denorm_flush got=%h exp=%h", res, {2'b00, 32'h3F800000}); end
    endtask

    task automatic test_stall();
        logic [33:0] expv [3];
        logic [31:0] ra, rb;
        logic rop;
        int bad;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            gen_op(ra, rb, rop);
            bus.a = ra; bus.b = rb; bus.op = rop;
            bus.in_valid = 1'b1; bus.out_ready = 1'b0;
            expv[i] = ref_model(ra, rb, rop);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1)
                begin failures++; $display("FAIL stall_accept%0d got=%b exp=1", i, bus.in_ready); end
        end
        @(posedge clk); #1;
        bus.a = 32'h40400000; bus.b = 32'h40400000; bus.op = OP_ADD;
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01)
            begin failures++; $display("FAIL stall_ready got=%b exp=01", {bus.in_ready, bus.out_valid}); end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if ({bus.in_ready, bus.out_valid, bus.ovf, bus.zero, bus.p} !== {2'b01, expv[0]}) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d exp=0", bad); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({bus.out_valid, bus.ovf, bus.zero, bus.p} !== {1'b1, expv[i]})
                begin failures++; $display("FAIL drain%0d got=%h exp=%h", i,
                    {bus.out_valid, bus.ovf, bus.zero, bus.p}, {1'b1, expv[i]}); end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL drain_end got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [33:0] expv [8];
        logic [31:0] ra, rb;
        logic rop;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = (c < 8);
            if (c < 8) begin
                gen_op(ra, rb, rop);
                bus.a = ra; bus.b = rb; bus.op = rop;
                expv[c] = ref_model(ra, rb, rop);
            end
            #1;
            checks++;
            if (c >= 3 && c < 11) begin
                if ({bus.in_ready, bus.out_valid, bus.ovf, bus.zero, bus.p} !== {2'b11, expv[c-3]})
                    begin failures++; $display("FAIL b2b_c%0d got=%h exp=%h", c,
                        {bus.in_ready, bus.out_valid, bus.ovf, bus.zero, bus.p}, {2'b11, expv[c-3]}); end
            end else if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_idle_c%0d got=%b exp=10", c, {bus.in_ready, bus.out_valid});
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [33:0] q[$];
        logic [33:0] expv;
        logic [31:0] ra, rb, held_p;
        logic rop, held;
        held = 1'b0;
        held_p = '0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            if (held) begin
                checks++;
                if (bus.p !== held_p)
                    begin failures++; $display("FAIL rnd_hold c=%0d got=%h exp=%h", c, bus.p, held_p); end
            end
            gen_op(ra, rb, rop);
            bus.a = ra; bus.b = rb; bus.op = rop;
            bus.in_valid  = (c < 600) && ($urandom_range(3, 0) != 0);
            bus.out_ready = (c >= 600) || ($urandom_range(3, 0) != 0);
            #1;
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready))
                begin failures++; $display("FAIL rnd_in_ready c=%0d got=%b", c, bus.in_ready); end
            if (bus.in_valid && bus.in_ready) q.push_back(ref_model(ra, rb, rop));
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra c=%0d got=%h exp=none", c, bus.p);
                end else begin
                    expv = q.pop_front();
                    if ({bus.ovf, bus.zero, bus.p} !== expv)
                        begin failures++; $display("FAIL rnd_result c=%0d got=%h exp=%h", c,
                            {bus.ovf, bus.zero, bus.p}, expv); end
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_p = bus.p;
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] ra, rb;
        logic rop;
        int bad;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            gen_op(ra, rb, rop);
            bus.a = ra; bus.b = rb; bus.op = rop;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL rst_mid_during got=%b exp=0", bus.out_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rst_mid_stale bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 Parameter E_W, default 8, exponent field width in bits.
REQ-002 Parameter M_W, default 23, stored mantissa field width in bits (hidden bit not stored).
REQ-003 Operand/result format SHALL be {sign[1], exp[E_W], mant[M_W]}, total W = 1+E_W+M_W.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair and op presented.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 op  in  1  0 = a+b, 1 = a-b.
REQ-009 a  in  W  operand A.
REQ-010 b  in  W  operand B.
REQ-011 out_valid  out  1  result p valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 p  out  W  packed result.
REQ-014 ovf  out  1  result exponent overflowed, qualified by out_valid.
REQ-015 zero  out  1  result is zero, qualified by out_valid.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Pipeline SHALL have 3 stages: S1 compare/swap/align; S2 mantissa add/sub; S3 normalise/round/pack.
REQ-018 Latency SHALL be 3 cycles from input transfer to out_valid with no stall; throughput one op per cycle.
REQ-019 Global stall: advance = !out_valid || out_ready; in_ready = advance; no stage SHALL move when advance = 0.
REQ-020 While stalled, p, ovf, zero SHALL be held stable.
REQ-021 exp == 0 SHALL be treated as zero (denormals flushed); otherwise the hidden bit is 1.
REQ-022 Exp all-ones SHALL be treated as an ordinary value (no NaN/Inf decoding).
REQ-023 S1: effective sign of b = b.sign ^ op; larger magnitude is placed in the big slot; the smaller mantissa is right-shifted by the exponent difference, keeping guard, round and sticky bits; a shift of >= M_W+3 leaves sticky only.
REQ-024 S2: effective add when signs are equal, else big minus small; M_W+4-bit datapath plus carry; result sign = big sign.
REQ-025 S3: carry-out shifts right 1 (exp+1); otherwise left-normalise by the leading-zero count (exp-count).
REQ-026 Exp underflow (exp-count <= 0) or zero mantissa SHALL produce +0 (all bits 0), zero=1.
REQ-027 Result exp >= 2^E_W-1 SHALL produce {sign, all-ones exp, 0 mant}, ovf=1.
REQ-028 Equal magnitudes with opposite effective signs SHALL produce +0, zero=1.

Reset
REQ-029 On rst: all stage valid bits, out_valid, p, ovf, zero = 0; in_ready = 1 after release.
REQ-030 rst asserted mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.

Configuration
REQ-031 Macro FP_ADDSUB_ROUND_EN: when defined, S3 rounds to nearest-even using guard/round/sticky, and a rounding carry renormalises (exp+1, may set ovf); when undefined, S3 truncates guard/round/sticky. Latency is identical in both builds.

Structure
REQ-032 Package fp_pkg SHALL hold the op encoding constants (OP_ADD=0, OP_SUB=1) and a parametrised fp-field struct typedef.
REQ-033 Leading-zero count SHALL be a sub-module fp_lzc (width-parametrised, combinational), instantiated in S3.

Verification (E_W=8, M_W=23)
REQ-034 a=0x3F800000, b=0x3F800000, op=0 -> p=0x40000000, ovf=0, zero=0, out_valid exactly 3 cycles after transfer.
REQ-035 a=0x3F800000, b=0x3F800000, op=1 -> p=0x00000000, zero=1.
REQ-036 a=b=0x7F7FFFFF, op=0 -> p=0x7F800000, ovf=1.
REQ-037 a=0x3F800001, b=0x33800000, op=0 -> p=0x3F800002 with FP_ADDSUB_ROUND_EN; p=0x3F800001 without.
REQ-038 out_ready=0 with 3 ops accepted -> in_ready=0 and p stable; out_ready=1 -> results emerge in order, one per cycle.
REQ-039 rst pulsed with 2 ops in flight -> out_valid=0 during and after reset; no stale result is ever emitted.
